// File: rtl/zombie_round_ctrl_pkg.sv
// Shared types and constants for the punch-zombie round sequencer.
package zombie_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    DRAW,
    WAIT_HIT,
    HIT,
    MISS,
    OVER
  } state_t;

  localparam logic [3:0] LED_OFF   = 4'b0000;
  localparam logic [3:0] LED_OVER  = 4'b0001;
  localparam logic [7:0] SCORE_MAX = 8'd255;

  // LED pattern for zombie t (1..3); led[0] is reserved for the game-over lamp.
  function automatic logic [3:0] led_of(input logic [1:0] t);
    logic [3:0] v;
    v = 4'b0001 << t;
    return v;
  endfunction

endpackage

// File: rtl/zombie_round_ctrl_if.sv
// Game-side bundle: player/generator inputs and LED/score/status outputs.
interface zombie_round_ctrl_if;
  logic       start;
  logic [2:0] btn;
  logic [1:0] rnd;
  logic       rnd_req;
  logic [3:0] led;
  logic [7:0] score;
  logic [1:0] lives;
  logic       busy;
  logic       game_over;

  modport master (
    output start, btn, rnd,
    input  rnd_req, led, score, lives, busy, game_over
  );

  modport slave (
    input  start, btn, rnd,
    output rnd_req, led, score, lives, busy, game_over
  );
endinterface

// File: rtl/zombie_round_ctrl_tick_gen.sv
// Game tick prescaler. tick marks the terminal count; pre_tick marks the
// cycle before it so registered outputs can be lined up with a tick.
// Needs TICK_CYCLES >= 2.
module zombie_tick_gen #(
  parameter int TICK_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(TICK_CYCLES - 2);

  logic [CW-1:0] cnt;

  // Free-running 0..TICK_CYCLES-1 counter, restarted by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clr || cnt == TERM)  cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  assign tick     = (cnt == TERM);
  assign pre_tick = (cnt == PRE);
endmodule

// File: rtl/zombie_round_ctrl.sv
// Punch-zombie round sequencer: gap, draw a target, light it, judge the press.
module zombie_round_ctrl
  import zombie_pkg::*;
#(
  parameter int TICK_CYCLES  = 500000,
  parameter int GAP_TICKS    = 20,
  parameter int WINDOW_TICKS = 100,
  parameter int LIVES        = 3
) (
  input logic clk,
  input logic rst,
  zombie_round_ctrl_if.slave bus
);
  localparam int TMAX = (GAP_TICKS > WINDOW_TICKS) ? GAP_TICKS : WINDOW_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] WIN_LAST   = TW'(WINDOW_TICKS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  state_t        state, state_n;
  logic [TW-1:0] tcnt;
  logic [2:0]    btn_d, rise, tgt_bit;
  logic [1:0]    target, target_n;
  logic          req_d;
  logic          clr, tick, pre_tick;
  logic          gap_pre, gap_done, win_done;

  logic       rnd_req_q, rnd_req_n;
  logic [3:0] led_q, led_n;
  logic [7:0] score_q, score_n;
  logic [1:0] lives_q, lives_n;
  logic       busy_q, busy_n;
  logic       go_q, go_n;

  // Tick counter and tick count restart whenever the state changes.
  assign clr = (state_n != state);

  zombie_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  assign rise    = bus.btn & ~btn_d;
  assign tgt_bit = 3'b001 << (target - 2'd1);

  // pre fires one cycle ahead so the registered rnd_req lands in the last GAP cycle.
  assign gap_pre  = pre_tick && (tcnt == GAP_LAST);
  assign gap_done = tick && (tcnt == GAP_LAST);
  assign win_done = tick && (tcnt == WIN_LAST);

  // Ticks elapsed in the current state; wrap in IDLE/OVER/DRAW is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tcnt <= '0;
    else if (clr)  tcnt <= '0;
    else if (tick) tcnt <= tcnt + TW'(1);
  end

  // Next state, game bookkeeping and the registered-output next values.
  always_comb begin
    state_n   = state;
    target_n  = target;
    score_n   = score_q;
    lives_n   = lives_q;
    rnd_req_n = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (bus.start) begin
          score_n = 8'd0;
          lives_n = LIVES_INIT;
          state_n = GAP;
        end
      end
      GAP: begin
        if (gap_pre)  rnd_req_n = 1'b1;
        if (gap_done) state_n   = DRAW;
      end
      DRAW: begin
        // rnd is only meaningful the cycle after a request.
        if (req_d) begin
          if (bus.rnd == 2'd0) begin
            rnd_req_n = 1'b1;
          end else begin
            target_n = bus.rnd;
            state_n  = WAIT_HIT;
          end
        end
      end
      WAIT_HIT: begin
        // A press outranks expiry; any mix of buttons counts as a miss.
        if (rise != 3'b000)  state_n = (rise == tgt_bit) ? HIT : MISS;
        else if (win_done)   state_n = MISS;
      end
      HIT: begin
        if (score_q != SCORE_MAX) score_n = score_q + 8'd1;
        state_n = GAP;
      end
      MISS: begin
        lives_n = lives_q - 2'd1;
        state_n = (lives_q == 2'd1) ? OVER : GAP;
      end
      default: state_n = IDLE;
    endcase

    led_n = LED_OFF;
    if (state_n == OVER)          led_n = LED_OVER;
    else if (state_n == WAIT_HIT) led_n = led_of(target_n);
    busy_n = !(state_n inside {IDLE, OVER});
    go_n   = (state_n == OVER);
  end

  // State, target, edge history and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      target    <= 2'd0;
      btn_d     <= 3'b000;
      req_d     <= 1'b0;
      rnd_req_q <= 1'b0;
      led_q     <= LED_OFF;
      score_q   <= 8'd0;
      lives_q   <= 2'd0;
      busy_q    <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      btn_d     <= bus.btn;
      req_d     <= rnd_req_q;
      rnd_req_q <= rnd_req_n;
      led_q     <= led_n;
      score_q   <= score_n;
      lives_q   <= lives_n;
      busy_q    <= busy_n;
      go_q      <= go_n;
    end
  end

  assign bus.rnd_req   = rnd_req_q;
  assign bus.led       = led_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.busy      = busy_q;
  assign bus.game_over = go_q;
endmodule

// File: tb/tb_zombie_round_ctrl.sv
// Bench for zombie_round_ctrl: scenario tasks plus randomized rounds against
// a rule-level game model (score/lives bookkeeping and round timing).
module tb_zombie_round_ctrl;
  localparam int TC = 4, GT = 2, WT = 5, LV = 3;
  localparam int GAP_CYC = TC * GT;
  localparam int WIN_CYC = TC * WT;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0, n_pass = 0;
  int   exp_score, exp_lives;

  zombie_round_ctrl_if bus();

  zombie_round_ctrl #(
    .TICK_CYCLES(TC), .GAP_TICKS(GT), .WINDOW_TICKS(WT), .LIVES(LV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic abort(input string what);
    n_chk++;
    $display("FAIL %s: timed out waiting for rnd_req", what);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "bench stopped");
  endtask

  // Advance to the next negedge at which rnd_req is high; cyc = negedges moved.
  task automatic wait_req(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) abort("wait_req");
    end while (bus.rnd_req !== 1'b1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One full round starting at the first GAP negedge, ending at the negedge
  // where the HIT/MISS bookkeeping is visible.
  task automatic do_round(input int tgt, input int nzero, input logic [2:0] pat,
                          input int d, input logic [2:0] hold,
                          output int gap_cyc, output int extra,
                          output logic [3:0] led_w, output logic [3:0] led_dec,
                          output logic [7:0] score_dec, output logic [1:0] lives_dec);
    int c;
    bus.btn = hold;
    wait_req(gap_cyc);
    extra = 0;
    for (int z = 0; z < nzero; z++) begin
      bus.rnd = 2'd0;
      wait_req(c);
      extra++;
    end
    bus.rnd = 2'(tgt);
    @(negedge clk);
    if (bus.rnd_req === 1'b1) extra++;
    @(negedge clk);
    if (bus.rnd_req === 1'b1) extra++;
    led_w = bus.led;
    if (pat != 3'b000) begin
      repeat (d) @(negedge clk);
      bus.btn = hold | pat;
      @(negedge clk);
      bus.btn = hold;
    end else begin
      repeat (WIN_CYC) @(negedge clk);
    end
    led_dec   = bus.led;
    score_dec = bus.score;
    lives_dec = bus.lives;
    @(negedge clk);
    bus.btn = 3'b000;
  endtask

  task automatic test_reset();
    bit seen = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.btn = 3'b000; bus.rnd = 2'd0;
    repeat (3) @(negedge clk);
    n_chk++; if (bus.led !== 4'b0000) $display("FAIL reset_led got %b exp 0000", bus.led); else n_pass++;
    n_chk++; if (bus.score !== 8'd0) $display("FAIL reset_score got %0d exp 0", bus.score); else n_pass++;
    n_chk++; if (bus.lives !== 2'd0) $display("FAIL reset_lives got %0d exp 0", bus.lives); else n_pass++;
    n_chk++; if ({bus.rnd_req, bus.busy, bus.game_over} !== 3'b000)
      $display("FAIL reset_flags got %b exp 000", {bus.rnd_req, bus.busy, bus.game_over}); else n_pass++;
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rnd_req !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    n_chk++; if (seen) $display("FAIL idle_quiet got activity exp none"); else n_pass++;
  endtask

  task automatic test_start();
    int gc, ex; logic [3:0] lw, ld; logic [7:0] sd; logic [1:0] lvd;
    pulse_start();
    exp_score = 0; exp_lives = LV;
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL start_busy got %b exp 1", bus.busy); else n_pass++;
    n_chk++; if (bus.lives !== 2'(LV)) $display("FAIL start_lives got %0d exp %0d", bus.lives, LV); else n_pass++;
    do_round(2, 0, 3'b010, $urandom_range(0, WIN_CYC - 1), 3'b000, gc, ex, lw, ld, sd, lvd);
    exp_score = 1;
    n_chk++; if (gc !== GAP_CYC - 1) $display("FAIL gap_len got %0d exp %0d", gc + 1, GAP_CYC); else n_pass++;
    n_chk++; if (ex !== 0) $display("FAIL req_single got %0d extra exp 0", ex); else n_pass++;
    n_chk++; if (lw !== 4'b0100) $display("FAIL start_led got %b exp 0100", lw); else n_pass++;
    n_chk++; if (ld !== 4'b0000 || sd !== 8'd0) $display("FAIL hit_cycle got led %b score %0d exp 0000 0", ld, sd); else n_pass++;
    n_chk++; if (bus.score !== 8'd1) $display("FAIL hit_score got %0d exp 1", bus.score); else n_pass++;
    n_chk++; if (bus.lives !== 2'd3) $display("FAIL hit_lives got %0d exp 3", bus.lives); else n_pass++;
  endtask

  task automatic test_miss();
    int gc, ex, t, w; logic [3:0] lw, ld; logic [7:0] sd; logic [1:0] lvd;
    bit seen = 0;
    do_round(3, 0, 3'b000, 0, 3'b000, gc, ex, lw, ld, sd, lvd);
    n_chk++; if (lw !== 4'b1000) $display("FAIL miss_led got %b exp 1000", lw); else n_pass++;
    n_chk++; if (lvd !== 2'd3) $display("FAIL window_edge got lives %0d exp 3", lvd); else n_pass++;
    n_chk++; if (bus.lives !== 2'd2) $display("FAIL timeout_lives got %0d exp 2", bus.lives); else n_pass++;
    t = $urandom_range(1, 3);
    w = (t % 3);  // a button other than t-1
    do_round(t, 0, 3'b001 << w, $urandom_range(0, WIN_CYC - 1), 3'b000, gc, ex, lw, ld, sd, lvd);
    n_chk++; if (bus.lives !== 2'd1) $display("FAIL wrong_btn_lives got %0d exp 1", bus.lives); else n_pass++;
    do_round($urandom_range(1, 3), 0, 3'b000, 0, 3'b000, gc, ex, lw, ld, sd, lvd);
    n_chk++; if ({bus.game_over, bus.busy} !== 2'b10) $display("FAIL over_flags got %b exp 10", {bus.game_over, bus.busy}); else n_pass++;
    n_chk++; if (bus.led !== 4'b0001) $display("FAIL over_led got %b exp 0001", bus.led); else n_pass++;
    n_chk++; if (bus.lives !== 2'd0 || bus.score !== 8'd1)
      $display("FAIL over_hold got lives %0d score %0d exp 0 1", bus.lives, bus.score); else n_pass++;
    repeat (12) begin
      @(negedge clk);
      if (bus.rnd_req !== 1'b0 || bus.led !== 4'b0001) seen = 1;
    end
    n_chk++; if (seen) $display("FAIL over_quiet got activity exp none"); else n_pass++;
    pulse_start();
    exp_score = 0; exp_lives = LV;
    n_chk++; if ({bus.score, bus.lives, bus.busy, bus.game_over} !== {8'd0, 2'd3, 1'b1, 1'b0})
      $display("FAIL restart got score %0d lives %0d busy %b go %b exp 0 3 1 0",
               bus.score, bus.lives, bus.busy, bus.game_over); else n_pass++;
  endtask

  task automatic test_anti_mash();
    int gc, ex; logic [3:0] lw, ld; logic [7:0] sd; logic [1:0] lvd;
    do_round(1, 0, 3'b011, $urandom_range(0, WIN_CYC - 1), 3'b000, gc, ex, lw, ld, sd, lvd);
    n_chk++; if (bus.lives !== 2'd2 || bus.score !== 8'd0)
      $display("FAIL mash got lives %0d score %0d exp 2 0", bus.lives, bus.score); else n_pass++;
    do_round(1, 0, 3'b000, 0, 3'b001, gc, ex, lw, ld, sd, lvd);
    n_chk++; if (bus.lives !== 2'd1 || bus.score !== 8'd0)
      $display("FAIL held_btn got lives %0d score %0d exp 1 0", bus.lives, bus.score); else n_pass++;
    exp_lives = 1;
  endtask

  task automatic test_zero_redraw();
    int gc, ex; logic [3:0] lw, ld; logic [7:0] sd; logic [1:0] lvd;
    do_round(3, 2, 3'b100, $urandom_range(0, WIN_CYC - 1), 3'b000, gc, ex, lw, ld, sd, lvd);
    n_chk++; if (ex !== 2) $display("FAIL redraw_reqs got %0d exp 2", ex); else n_pass++;
    n_chk++; if (lw !== 4'b1000) $display("FAIL redraw_led got %b exp 1000", lw); else n_pass++;
    n_chk++; if (bus.score !== 8'd1 || bus.lives !== 2'd1)
      $display("FAIL redraw_hit got score %0d lives %0d exp 1 1", bus.score, bus.lives); else n_pass++;
  endtask

  task automatic test_saturate();
    int gc, ex, t; logic [3:0] lw, ld; logic [7:0] sd; logic [1:0] lvd;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 255; i++) begin
      t = $urandom_range(1, 3);
      do_round(t, 0, 3'b001 << (t - 1), 0, 3'b000, gc, ex, lw, ld, sd, lvd);
    end
    n_chk++; if (bus.score !== 8'd255) $display("FAIL score_255 got %0d exp 255", bus.score); else n_pass++;
    t = $urandom_range(1, 3);
    do_round(t, 0, 3'b001 << (t - 1), 0, 3'b000, gc, ex, lw, ld, sd, lvd);
    n_chk++; if (bus.score !== 8'd255) $display("FAIL score_sat got %0d exp 255", bus.score); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c; bit seen = 0;
    wait_req(c);
    bus.rnd = 2'd2;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.led !== 4'b0100) $display("FAIL mid_led got %b exp 0100", bus.led); else n_pass++;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({bus.led, bus.score, bus.lives} !== 14'd0)
      $display("FAIL async_rst got led %b score %0d lives %0d exp 0 0 0", bus.led, bus.score, bus.lives); else n_pass++;
    n_chk++; if ({bus.rnd_req, bus.busy, bus.game_over} !== 3'b000)
      $display("FAIL async_rst_flags got %b exp 000", {bus.rnd_req, bus.busy, bus.game_over}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rnd_req !== 1'b0 || bus.busy !== 1'b0) seen = 1;
    end
    n_chk++; if (seen) $display("FAIL post_rst_idle got activity exp none"); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int c;
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    wait_req(c);
    n_chk++; if (c !== GAP_CYC - 4) $display("FAIL start_in_gap got %0d exp %0d", c, GAP_CYC - 4); else n_pass++;
    bus.rnd = 2'd1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.led !== 4'b0010) $display("FAIL ign_led got %b exp 0010", bus.led); else n_pass++;
    bus.btn = 3'b001;
    @(negedge clk);
    bus.btn = 3'b000;
    @(negedge clk);
    n_chk++; if (bus.score !== 8'd1 || bus.lives !== 2'd3)
      $display("FAIL ign_state got score %0d lives %0d exp 1 3", bus.score, bus.lives); else n_pass++;
    exp_score = 1; exp_lives = LV;
  endtask

  // Random rounds judged by the game rules: exactly the lit zombie's button
  // scores, any other press or silence costs a life, zero lives ends the game.
  task automatic test_random();
    int gc, ex, t, a, k, nz; logic [2:0] good, pat; logic [3:0] lw, ld, el;
    logic [7:0] sd; logic [1:0] lvd;
    for (int r = 0; r < 40; r++) begin
      t = $urandom_range(1, 3);
      a = $urandom_range(0, 3);
      nz = $urandom_range(0, 1);
      good = 3'b001 << (t - 1);
      k = (t - 1 + $urandom_range(1, 2)) % 3;
      case (a)
        0: pat = good;
        1: pat = 3'b001 << k;
        2: pat = good | (3'b001 << k);
        default: pat = 3'b000;
      endcase
      do_round(t, nz, pat, $urandom_range(0, WIN_CYC - 1), 3'b000, gc, ex, lw, ld, sd, lvd);
      if (pat == good) exp_score = (exp_score < 255) ? exp_score + 1 : 255;
      else             exp_lives = exp_lives - 1;
      el = 4'b0001 << t;
      n_chk++; if (gc !== GAP_CYC - 1 || ex !== nz)
        $display("FAIL rnd%0d_draw got gap %0d reqs %0d exp %0d %0d", r, gc + 1, ex, GAP_CYC, nz); else n_pass++;
      n_chk++; if (lw !== el) $display("FAIL rnd%0d_led got %b exp %b", r, lw, el); else n_pass++;
      n_chk++; if (bus.score !== 8'(exp_score) || bus.lives !== 2'(exp_lives))
        $display("FAIL rnd%0d_tally got score %0d lives %0d exp %0d %0d", r, bus.score, bus.lives, exp_score, exp_lives);
      else n_pass++;
      if (exp_lives == 0) begin
        n_chk++; if (bus.game_over !== 1'b1 || bus.led !== 4'b0001)
          $display("FAIL rnd%0d_over got go %b led %b exp 1 0001", r, bus.game_over, bus.led); else n_pass++;
        repeat (3) @(negedge clk);
        pulse_start();
        exp_score = 0; exp_lives = LV;
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_miss();
    test_anti_mash();
    test_zero_redraw();
    test_saturate();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
